// File: rtl/noc_port_buf.sv
// ---------------------------------------------------------------------------
// noc_port_buf
// Ingress buffer for one NOC port. Inbound {ctl,data} words are stored in a
// DEPTH-deep FIFO, except idle words (ctl=1, data=0), which are never stored.
// A registered output stage presents the FIFO head downstream.
//
// When a frame overflows the FIFO, the block drops the rest of that frame
// and counts the truncation. Words of the frame that were already stored are
// kept and forwarded.
//
// Handshake: noc_from_dev_{ctl,data} is always a valid word, which may be
// idle. A word is consumed on a rising edge where from_ready=1. On that edge
// the output register loads the FIFO head, or the idle word if the FIFO is
// empty. When from_ready=0, the output register holds its value.
//
// Ports
//   clk, reset          : clock; synchronous active-high reset
//   noc_to_dev_ctl/data : inbound word (ctl=1 command/idle, ctl=0 payload)
//   noc_from_dev_ctl/data: registered outbound word
//   from_ready          : downstream consumes the output word this cycle
//   fill                : FIFO occupancy (output register not counted)
//   drop_cnt            : truncated-frame count, saturating at 0xFFFF
//   ovf                 : sticky overflow flag, cleared only by reset
//   wr_state            : write FSM state (0 = PASS, 1 = DROP), for debug
// ---------------------------------------------------------------------------
module noc_port_buf #(
   parameter int DW    = 8,
   parameter int DEPTH = 16
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     noc_to_dev_ctl,
   input  logic [DW-1:0]            noc_to_dev_data,
   output logic                     noc_from_dev_ctl,
   output logic [DW-1:0]            noc_from_dev_data,
   input  logic                     from_ready,
   output logic [$clog2(DEPTH):0]   fill,
   output logic [15:0]              drop_cnt,
   output logic                     ovf,
   output logic                     wr_state
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

   typedef enum logic {PASS = 1'b0, DROP = 1'b1} state_t;

   state_t          state_q, state_d;
   logic [DW:0]     mem [DEPTH];
   logic [AW-1:0]   wr_ptr, rd_ptr;
   logic [AW:0]     fill_q;

   logic in_idle, in_hdr, pop, room, attempt, wr_en, drop_evt;

   always_comb begin
      in_idle  = noc_to_dev_ctl && (noc_to_dev_data == '0);
      in_hdr   = noc_to_dev_ctl && (noc_to_dev_data != '0);
      pop      = from_ready && (fill_q != '0);
      // A pop in the same cycle frees a slot, so a full FIFO can still accept.
      room     = (fill_q != FULL_LVL) || pop;
      // In DROP, only a header gets a write attempt. Payload and idle words
      // are ignored.
      attempt  = !in_idle && ((state_q == PASS) || in_hdr);
      wr_en    = attempt && room;
      drop_evt = attempt && !room;
   end

   // Write FSM: next-state logic
   always_comb begin
      state_d = state_q;
      if (drop_evt)
         state_d = DROP;
      else if (wr_en)
         state_d = PASS;
   end

   always_ff @(posedge clk) begin
      if (reset)
         state_q <= PASS;
      else
         state_q <= state_d;
   end

   // Storage array, with no reset. A flush only needs the pointers and fill
   // to be cleared.
   always_ff @(posedge clk) begin
      if (!reset && wr_en)
         mem[wr_ptr] <= {noc_to_dev_ctl, noc_to_dev_data};
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         fill_q <= '0;
      end else begin
         // DEPTH is a power of two, so the pointers wrap naturally.
         if (wr_en)
            wr_ptr <= wr_ptr + 1'b1;
         if (pop)
            rd_ptr <= rd_ptr + 1'b1;
         case ({wr_en, pop})
            2'b10:   fill_q <= fill_q + 1'b1;
            2'b01:   fill_q <= fill_q - 1'b1;
            default: fill_q <= fill_q;
         endcase
      end
   end

   // Output stage
   always_ff @(posedge clk) begin
      if (reset) begin
         noc_from_dev_ctl  <= 1'b1;
         noc_from_dev_data <= '0;
      end else if (from_ready) begin
         if (pop) begin
            noc_from_dev_ctl  <= mem[rd_ptr][DW];
            noc_from_dev_data <= mem[rd_ptr][DW-1:0];
         end else begin
            noc_from_dev_ctl  <= 1'b1;
            noc_from_dev_data <= '0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         drop_cnt <= '0;
         ovf      <= 1'b0;
      end else if (drop_evt) begin
         ovf <= 1'b1;
         if (drop_cnt != 16'hFFFF)
            drop_cnt <= drop_cnt + 16'd1;
      end
   end

   assign fill     = fill_q;
   assign wr_state = state_q;

endmodule

// File: tb/tb_noc_port_buf.sv
// Bench for noc_port_buf with DW=8 and DEPTH=4.
// The driver applies one input word per cycle. At the same time it advances a
// queue-based reference model to the state expected after the next rising
// edge. Every output word the model expects is pushed into exp_q. The monitor
// checks the DUT just after each rising edge.
module tb_noc_port_buf;
  localparam int DW    = 8;
  localparam int DEPTH = 4;
  localparam logic [DW:0] IDLE_W = {1'b1, {DW{1'b0}}};

  logic          clk;
  logic          reset;
  logic          noc_to_dev_ctl;
  logic [DW-1:0] noc_to_dev_data;
  logic          noc_from_dev_ctl;
  logic [DW-1:0] noc_from_dev_data;
  logic          from_ready;
  logic [2:0]    fill;
  logic [15:0]   drop_cnt;
  logic          ovf;
  logic          wr_state;

  noc_port_buf #(.DW(DW), .DEPTH(DEPTH)) dut (
    .clk               (clk),
    .reset             (reset),
    .noc_to_dev_ctl    (noc_to_dev_ctl),
    .noc_to_dev_data   (noc_to_dev_data),
    .noc_from_dev_ctl  (noc_from_dev_ctl),
    .noc_from_dev_data (noc_from_dev_data),
    .from_ready        (from_ready),
    .fill              (fill),
    .drop_cnt          (drop_cnt),
    .ovf               (ovf),
    .wr_state          (wr_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model and scoreboard ----------------
  logic [DW:0]  model_q[$];   // stored words, in arrival order
  logic [DW:0]  exp_q[$];     // output words expected, one per consumed edge
  logic         m_dropping;   // currently discarding the rest of a frame
  int           m_drops;
  logic         m_ovf;
  logic [DW:0]  exp_last;
  bit           mon_en;
  int           checks;
  int           errors;

  initial begin
    m_dropping = 1'b0;
    m_drops    = 0;
    m_ovf      = 1'b0;
    exp_last   = IDLE_W;
    mon_en     = 1'b0;
    checks     = 0;
    errors     = 0;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- driver ----------------
  task automatic step(input logic c, input logic [DW-1:0] d, input logic rdy, input logic rst);
    bit room, popping, nonidle, hdr;
    logic [DW:0] w;
    @(negedge clk);
    noc_to_dev_ctl  = c;
    noc_to_dev_data = d;
    from_ready      = rdy;
    reset           = rst;
    if (rst) begin
      model_q.delete();
      m_dropping = 1'b0;
      m_drops    = 0;
      m_ovf      = 1'b0;
    end else begin
      popping = rdy && (model_q.size() > 0);
      room    = (model_q.size() < DEPTH) || popping;
      if (rdy) begin
        if (popping) w = model_q.pop_front();
        else         w = IDLE_W;
        exp_q.push_back(w);
      end
      nonidle = !(c && d == '0);
      hdr     = c && d != '0;
      if (nonidle && (!m_dropping || hdr)) begin
        if (room) begin
          model_q.push_back({c, d});
          m_dropping = 1'b0;
        end else begin
          m_dropping = 1'b1;
          if (m_drops < 16'hFFFF) m_drops++;
          m_ovf = 1'b1;
        end
      end
    end
    mon_en = 1'b1;
  endtask

  task automatic idle_cycles(input int n, input logic rdy);
    for (int i = 0; i < n; i++) step(1'b1, '0, rdy, 1'b0);
  endtask

  // ---------------- monitor ----------------
  always @(posedge clk) begin
    logic rs, rd;
    rs = reset;
    rd = from_ready;
    #1;
    if (mon_en) begin
      if (rs) begin
        exp_last = IDLE_W;
      end else if (rd) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL scoreboard: no expected word queued at %0t", $time);
        end else begin
          exp_last = exp_q.pop_front();
        end
      end
      chk("out_word", {23'd0, noc_from_dev_ctl, noc_from_dev_data}, {23'd0, exp_last});
      chk("fill", {29'd0, fill}, model_q.size());
      chk("drop_cnt", {16'd0, drop_cnt}, m_drops);
      chk("ovf", {31'd0, ovf}, {31'd0, m_ovf});
      chk("wr_state", {31'd0, wr_state}, {31'd0, m_dropping});
    end
  end

  // Explicit checks land between the monitor sample and the next drive.
  task automatic settle();
    @(posedge clk);
    #2;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    reset           = 1'b1;
    from_ready      = 1'b0;
    noc_to_dev_ctl  = 1'b1;
    noc_to_dev_data = '0;

    // Reset for two cycles, then check the reset values.
    step(1'b1, '0, 1'b0, 1'b1);
    step(1'b1, '0, 1'b0, 1'b1);
    settle();
    chk("rst_ctl", {31'd0, noc_from_dev_ctl}, 32'd1);
    chk("rst_data", {24'd0, noc_from_dev_data}, 32'd0);
    chk("rst_fill", {29'd0, fill}, 32'd0);

    // Pass-through of a short frame. The monitor checks the timing.
    idle_cycles(2, 1'b1);
    step(1'b1, 8'h01, 1'b1, 1'b0);
    step(1'b0, 8'hAA, 1'b1, 1'b0);
    step(1'b0, 8'hBB, 1'b1, 1'b0);
    idle_cycles(5, 1'b1);

    // Overflow: a header plus five payload words while the output is stalled.
    step(1'b1, 8'h05, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b0, 8'h10 + 8'(i), 1'b0, 1'b0);
    settle();
    chk("ovf_fill", {29'd0, fill}, 32'd4);
    chk("ovf_flag", {31'd0, ovf}, 32'd1);
    chk("ovf_drops", {16'd0, drop_cnt}, 32'd1);
    idle_cycles(7, 1'b1);

    // While in DROP with space available, a header resumes the frame stream.
    chk("drop_state", {31'd0, wr_state}, 32'd1);
    step(1'b1, 8'h02, 1'b1, 1'b0);
    settle();
    chk("hdr_state", {31'd0, wr_state}, 32'd0);
    chk("hdr_drops", {16'd0, drop_cnt}, 32'd1);
    idle_cycles(4, 1'b1);

    // With the FIFO full, a write is accepted in the same cycle as a pop.
    step(1'b1, 8'h07, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, 8'h20 + 8'(i), 1'b0, 1'b0);
    step(1'b0, 8'h33, 1'b1, 1'b0);
    settle();
    chk("full_pop_fill", {29'd0, fill}, 32'd4);
    chk("full_pop_drops", {16'd0, drop_cnt}, 32'd1);
    idle_cycles(6, 1'b1);

    // Reset mid-frame flushes the FIFO. Payload words after the reset are stored.
    step(1'b1, 8'h09, 1'b0, 1'b0);
    step(1'b0, 8'h41, 1'b0, 1'b0);
    step(1'b0, 8'h42, 1'b0, 1'b0);
    step(1'b0, 8'h43, 1'b0, 1'b1);
    settle();
    chk("mid_rst_fill", {29'd0, fill}, 32'd0);
    chk("mid_rst_ctl", {31'd0, noc_from_dev_ctl}, 32'd1);
    chk("mid_rst_drops", {16'd0, drop_cnt}, 32'd0);
    step(1'b0, 8'h51, 1'b0, 1'b0);
    step(1'b0, 8'h52, 1'b0, 1'b0);
    settle();
    chk("post_rst_fill", {29'd0, fill}, 32'd2);
    idle_cycles(4, 1'b1);

    // Randomised traffic with bursty back-pressure and occasional resets.
    begin
      int rdy_pct;
      rdy_pct = 50;
      for (int n = 0; n < 2000; n++) begin
        int kind;
        logic c;
        logic [DW-1:0] d;
        logic r, rs;
        if (n % 32 == 0) rdy_pct = $urandom_range(10, 90);
        kind = $urandom_range(0, 9);
        if (kind < 2) begin
          c = 1'b1; d = '0;
        end else if (kind < 4) begin
          c = 1'b1; d = DW'($urandom_range(1, 255));
        end else begin
          c = 1'b0; d = DW'($urandom_range(0, 255));
        end
        r  = ($urandom_range(0, 99) < rdy_pct);
        rs = ($urandom_range(0, 199) == 0);
        step(c, d, r, rs);
      end
    end
    idle_cycles(8, 1'b1);
    settle();
    mon_en = 1'b0;
    chk("exp_q_drained", exp_q.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/noc_port_buf.md
NOC_PORT_BUF -- requirements
Module: noc_port_buf

Interface
REQ-001 Parameter DW, default 8: NOC data width in bits, legal 8..64.
REQ-002 Parameter DEPTH, default 16: FIFO entries, power of two, legal 2..256.
REQ-003 Port clk  in  1: single clock; all state changes on rising edge.
REQ-004 Port reset  in  1: synchronous, active-high reset.
REQ-005 Port noc_to_dev_ctl  in  1: inbound control flag; 1 = command/idle word, 0 = payload word.
REQ-006 Port noc_to_dev_data  in  DW: inbound data word.
REQ-007 Port noc_from_dev_ctl  out  1: outbound control flag, registered.
REQ-008 Port noc_from_dev_data  out  DW: outbound data word, registered.
REQ-009 Port from_ready  in  1: downstream accepts the current output word this cycle.
REQ-010 Port fill  out  $clog2(DEPTH)+1: current FIFO occupancy; excludes the output register.
REQ-011 Port drop_cnt  out  16: count of frames truncated by overflow, saturating.
REQ-012 Port ovf  out  1: sticky overflow flag.

Function
REQ-013 Idle word is ctl=1 and data=0; the block SHALL never store it.
REQ-014 Header word is ctl=1 and data!=0; it starts a frame. Payload words are ctl=0.
REQ-015 The FIFO SHALL store {ctl,data} entries in arrival order, DEPTH deep, with wrap-around read/write pointers.
REQ-016 Pop occurs when from_ready=1 and fill>0. Output register loads the FIFO head on that edge.
REQ-017 When from_ready=1 and fill=0, output register SHALL load the idle word.
REQ-018 When from_ready=0, output register SHALL hold its value.
REQ-019 A non-idle input word SHALL be written when the state is PASS and either fill<DEPTH or a pop occurs the same cycle.
REQ-020 Simultaneous write and pop SHALL leave fill unchanged.
REQ-021 Latency: a word written at edge N SHALL appear on the outputs after edge N+1 at the earliest, i.e. visible in cycle N+2, when from_ready=1 and the FIFO was empty.
REQ-022 The write state machine SHALL have two states, PASS and DROP, with PASS as the reset state.
REQ-023 PASS->DROP transition: a non-idle word arrives when it cannot be written (fill=DEPTH, no pop). That word is discarded, drop_cnt increments by 1 (saturating at 0xFFFF), and ovf is set.
REQ-024 In DROP, payload words SHALL be discarded without further drop_cnt increments.
REQ-025 In DROP, a header word SHALL return the state to PASS. The header is evaluated in the same cycle under REQ-019 and REQ-023.
REQ-026 If that header cannot be written, the state SHALL stay DROP and drop_cnt SHALL increment again.
REQ-027 Idle words SHALL not change the state machine.
REQ-028 Words of a truncated frame that were already stored SHALL remain stored and be forwarded.
REQ-029 fill SHALL increment on write only, decrement on pop only, and never exceed DEPTH or go below 0.

Reset
REQ-030 On reset: noc_from_dev_ctl=1, noc_from_dev_data=0, fill=0, drop_cnt=0, ovf=0, state PASS, pointers 0.
REQ-031 Reset asserted mid-frame SHALL flush all FIFO contents. The input word present during the reset cycle SHALL be ignored.
REQ-032 ovf SHALL clear only on reset.

Verification (DW=8, DEPTH=4)
REQ-033 Assert reset 2 cycles -> outputs ctl=1/data=0x00, fill=0, drop_cnt=0, ovf=0.
REQ-034 from_ready=1; drive header 0x01, payload 0xAA, 0xBB starting cycle N -> output 0x01(ctl1), 0xAA(ctl0), 0xBB(ctl0) in cycles N+2..N+4, then idle.
REQ-035 from_ready=0; drive header 0x05 plus 5 payload words -> fill=4, ovf=1, drop_cnt=1. Then from_ready=1 -> exactly the 4 stored words emerge, then idle.
REQ-036 In DROP with from_ready=1 and space available, drive header 0x02 -> 0x02 is stored and forwarded, state PASS, drop_cnt unchanged.
REQ-037 fill=4, from_ready=1, payload word driven -> word accepted, fill stays 4, no drop.
REQ-038 fill=3 mid-frame, assert reset -> next cycle fill=0 and outputs idle. Following payload-only words with no header are stored normally.
